hazard_forward_ctrl: RTL and testbench

//  Parametrised, stateful successor to the combinational forwarding unit. Tracks destination tags of
//  in-flight instructions (EX/MEM/WB) internally and issues registered per-source bypass selects.

---
 rtl/rv_hazard_pkg.sv | 24 ++
 rtl/hazard_forward_ctrl_fwd_src_match.sv | 41 ++++
 rtl/hazard_forward_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_forward_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_hazard_pkg.sv
// Shared types for the hazard/forwarding controller:
// bypass select codes, in-flight tag and counter sizing.
package rv_hazard_pkg;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  // Widest register address a tag can carry.
  localparam int RD_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } hazard_tag_t;

  // Counter holds at most LAT-1.
  function automatic int muldiv_cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_src_match.sv
// One source operand: compare against EX/MEM/WB tags,
// youngest-wins bypass select and EX load-use hit.
// Ports: src/src_use from ID, stage tags in, sel/load_hit out.
module fwd_src_match
  import rv_hazard_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic [ADDR_W-1:0]   src,
  input  logic                src_use,
  input  hazard_tag_t         ex,
  input  logic                mem_valid,
  input  logic [RD_MAX_W-1:0] mem_rd,
  input  logic                wb_valid,
  input  logic [RD_MAX_W-1:0] wb_rd,
  output logic [1:0]          sel,
  output logic                load_hit
);

  logic [RD_MAX_W-1:0] src_x;
  logic hit_ex, hit_mem, hit_wb;

  assign src_x   = RD_MAX_W'(src);
  assign hit_ex  = src_use & ex.valid & (ex.rd == src_x);
  assign hit_mem = src_use & mem_valid & (mem_rd == src_x);
  assign hit_wb  = src_use & wb_valid & (wb_rd == src_x);

  always_comb begin
    sel = FWD_NONE;
    priority case (1'b1)
      hit_ex:  sel = FWD_EXMEM;
      hit_mem: sel = FWD_MEMWB;
      hit_wb:  sel = FWD_WB;
      default: sel = FWD_NONE;
    endcase
  end

  assign load_hit = (LOAD_STALL != 0) & hit_ex & ex.is_load;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Stateful bypass/stall controller beside ID/EX: tracks EX/MEM/WB tags,
// registers per-source FWD_SEL, raises load-use and MUL/DIV stalls.
// In: CLK, RESET (sync, low), ID_* instruction fields, FLUSH.
// Out: FWD_SEL (reg), STALL (comb), MULDIV_BUSY (reg).
module hazard_forward_ctrl
  import rv_hazard_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int NUM_SRC    = 2,
  parameter int MULDIV_LAT = 4,
  parameter int LOAD_STALL = 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ID_VALID,
  input  logic [NUM_SRC*ADDR_W-1:0] ID_SRC,
  input  logic [NUM_SRC-1:0]        ID_SRC_USE,
  input  logic [ADDR_W-1:0]         ID_RD,
  input  logic                      ID_RD_WEN,
  input  logic                      ID_IS_LOAD,
  input  logic                      ID_IS_MULDIV,
  input  logic                      FLUSH,
  output logic [2*NUM_SRC-1:0]      FWD_SEL,
  output logic                      STALL,
  output logic                      MULDIV_BUSY
);

  localparam int CNT_W = muldiv_cnt_w(MULDIV_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit MD_MULTI = (MULDIV_LAT > 1);

  hazard_tag_t         id_tag;
  hazard_tag_t         ex_q;
  logic                mem_valid_q;
  logic [RD_MAX_W-1:0] mem_rd_q;
  logic                wb_valid_q;
  logic [RD_MAX_W-1:0] wb_rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*NUM_SRC-1:0] sel_d;
  logic [NUM_SRC-1:0]  lu_hit;
  logic                lu_stall;

  // x0 writes are dropped here so they never match.
  always_comb begin
    id_tag         = '0;
    id_tag.valid   = ID_VALID & ID_RD_WEN & (ID_RD != '0);
    id_tag.rd      = RD_MAX_W'(ID_RD);
    id_tag.is_load = ID_IS_LOAD;
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .ADDR_W     (ADDR_W),
      .LOAD_STALL (LOAD_STALL)
    ) u_match (
      .src       (ID_SRC[i*ADDR_W +: ADDR_W]),
      .src_use   (ID_SRC_USE[i]),
      .ex        (ex_q),
      .mem_valid (mem_valid_q),
      .mem_rd    (mem_rd_q),
      .wb_valid  (wb_valid_q),
      .wb_rd     (wb_rd_q),
      .sel       (sel_d[2*i +: 2]),
      .load_hit  (lu_hit[i])
    );
  end

  // A flush squashes the consumer, so no bubble is needed for it.
  assign lu_stall = ID_VALID & (|lu_hit) & ~FLUSH;
  assign STALL    = MULDIV_BUSY | lu_stall;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ex_q        <= '0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      cnt_q       <= '0;
      MULDIV_BUSY <= 1'b0;
      FWD_SEL     <= '0;
    end else if (MULDIV_BUSY) begin
      // EXE keeps the op and its selects; MEM drains a bubble.
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      wb_valid_q  <= mem_valid_q;
      wb_rd_q     <= mem_rd_q;
      cnt_q       <= cnt_q - CNT_ONE;
      MULDIV_BUSY <= (cnt_q != CNT_ONE);
    end else begin
      mem_valid_q <= ex_q.valid;
      mem_rd_q    <= ex_q.rd;
      wb_valid_q  <= mem_valid_q;
      wb_rd_q     <= mem_rd_q;
      if (FLUSH | lu_stall | ~ID_VALID) begin
        ex_q    <= '0;
        FWD_SEL <= '0;
      end else begin
        ex_q    <= id_tag;
        FWD_SEL <= sel_d;
        if (ID_IS_MULDIV && MD_MULTI) begin
          cnt_q       <= CNT_LOAD;
          MULDIV_BUSY <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: default instance and a
// NUM_SRC=3/ADDR_W=6 instance driven in lockstep.
module tb_hazard_forward_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, rd_wen, is_load, is_muldiv, flush;
  logic [9:0]  src1;
  logic [1:0]  use1;
  logic [4:0]  rd1;
  logic [17:0] src2;
  logic [2:0]  use2;
  logic [5:0]  rd2;
  logic [3:0]  fwd1;
  logic [5:0]  fwd2;
  logic st1, bz1, st2, bz2;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int         q_cyc[$];
  int         q_kind[$];
  logic [5:0] q_val[$];
  string      q_nm[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hazard_forward_ctrl u_dut1 (
    .CLK(clk), .RESET(rst_n), .ID_VALID(id_valid),
    .ID_SRC(src1), .ID_SRC_USE(use1), .ID_RD(rd1),
    .ID_RD_WEN(rd_wen), .ID_IS_LOAD(is_load),
    .ID_IS_MULDIV(is_muldiv), .FLUSH(flush),
    .FWD_SEL(fwd1), .STALL(st1), .MULDIV_BUSY(bz1)
  );

  hazard_forward_ctrl #(.ADDR_W(6), .NUM_SRC(3)) u_dut2 (
    .CLK(clk), .RESET(rst_n), .ID_VALID(id_valid),
    .ID_SRC(src2), .ID_SRC_USE(use2), .ID_RD(rd2),
    .ID_RD_WEN(rd_wen), .ID_IS_LOAD(is_load),
    .ID_IS_MULDIV(is_muldiv), .FLUSH(flush),
    .FWD_SEL(fwd2), .STALL(st2), .MULDIV_BUSY(bz2)
  );

  task automatic push(input int c, input int k,
                      input logic [5:0] v, input string nm);
    q_cyc.push_back(c);
    q_kind.push_back(k);
    q_val.push_back(v);
    q_nm.push_back(nm);
  endtask

  task automatic expect_all(input int c, input logic st,
                            input logic bz, input logic [3:0] f,
                            input logic [1:0] f3, input string nm);
    push(c, 0, {2'b00, f}, nm);
    push(c, 1, {5'd0, st}, nm);
    push(c, 2, {5'd0, bz}, nm);
    push(c, 3, {f3, f}, nm);
    push(c, 4, {5'd0, st}, nm);
    push(c, 5, {5'd0, bz}, nm);
  endtask

  // Expected STALL/BUSY this cycle, FWD_SEL next cycle.
  task automatic step(input logic v, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [1:0] u,
                      input logic [4:0] rd, input logic wen,
                      input logic ld, input logic md, input logic fl,
                      input logic [4:0] s3, input logic u3,
                      input logic e_st, input logic e_bz,
                      input logic [3:0] e_f, input logic [1:0] e_f3,
                      input string nm);
    id_valid  = v;
    src1      = {s2, s1};
    use1      = u;
    rd1       = rd;
    src2      = {1'b0, s3, 1'b0, s2, 1'b0, s1};
    use2      = {u3, u};
    rd2       = {1'b0, rd};
    rd_wen    = wen;
    is_load   = ld;
    is_muldiv = md;
    flush     = fl;
    push(cyc, 1, {5'd0, e_st}, nm);
    push(cyc, 2, {5'd0, e_bz}, nm);
    push(cyc, 4, {5'd0, e_st}, nm);
    push(cyc, 5, {5'd0, e_bz}, nm);
    push(cyc + 1, 0, {2'b00, e_f}, nm);
    push(cyc + 1, 3, {e_f3, e_f}, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "nop");
  endtask

  task automatic add_x5();
    step(1, 1, 2, 2'b11, 5, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "add_x5");
  endtask

  task automatic filler(input logic [4:0] rd);
    step(1, 0, 0, 2'b00, rd, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "filler");
  endtask

  task automatic lw_x7();
    step(1, 1, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "lw_x7");
  endtask

  task automatic mul_x10();
    step(1, 1, 2, 2'b11, 10, 1, 0, 1, 0, 0, 0, 0, 0, 4'h0, 2'b00, "mul_x10");
  endtask

  logic [5:0] act;
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      int k;
      logic [5:0] e;
      string nm;
      void'(q_cyc.pop_front());
      k  = q_kind.pop_front();
      e  = q_val.pop_front();
      nm = q_nm.pop_front();
      case (k)
        0:       act = {2'b00, fwd1};
        1:       act = {5'd0, st1};
        2:       act = {5'd0, bz1};
        3:       act = fwd2;
        4:       act = {5'd0, st2};
        default: act = {5'd0, bz2};
      endcase
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s kind=%0d cyc=%0d got=%b want=%b",
                 nm, k, cyc, act, e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 0; src1 = '0; use1 = '0; rd1 = '0;
    src2 = '0; use2 = '0; rd2 = '0;
    rd_wen = 0; is_load = 0; is_muldiv = 0; flush = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      id_valid  = 1'($urandom);
      src1      = 10'($urandom);
      use1      = 2'($urandom);
      rd1       = 5'($urandom);
      src2      = 18'($urandom);
      use2      = 3'($urandom);
      rd2       = 6'($urandom);
      rd_wen    = 1'($urandom);
      is_load   = 1'($urandom);
      is_muldiv = 1'($urandom);
      flush     = 1'($urandom);
      expect_all(cyc, 0, 0, 4'h0, 2'b00, "reset");
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    expect_all(cyc, 0, 0, 4'h0, 2'b00, "reset_exit");
    drain();

    add_x5();
    step(1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 2'b00, "fwd_exmem");
    drain();
    add_x5(); filler(20);
    step(1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 2'b00, "fwd_memwb");
    drain();
    add_x5(); filler(20); filler(21);
    step(1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2'b00, "fwd_wb");
    drain();
    add_x5(); filler(20); filler(21); filler(22);
    step(1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, "fwd_aged_out");
    drain();

    lw_x7();
    step(1, 7, 1, 2'b11, 8, 1, 0, 0, 0, 0, 0, 1, 0, 4'h0, 2'b00, "load_use_stall");
    step(1, 7, 1, 2'b11, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 2'b00, "load_use_memwb");
    drain();
    lw_x7();
    step(1, 7, 1, 2'b10, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "load_use_unused_src");
    drain();
    lw_x7();
    step(0, 7, 7, 2'b11, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "load_use_invalid_id");
    drain();

    step(1, 1, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "addi_x0");
    step(1, 0, 0, 2'b11, 9, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "x0_no_fwd");
    drain();
    step(1, 1, 2, 2'b11, 3, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "nowen_x3");
    step(1, 3, 3, 2'b11, 4, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 2'b00, "nowen_no_fwd");
    drain();

    mul_x10();
    step(1, 10, 1, 2'b11, 11, 1, 0, 0, 0, 10, 1, 1, 1, 4'h0, 2'b00, "muldiv_busy1");
    step(1, 10, 1, 2'b11, 11, 1, 0, 0, 1, 10, 1, 1, 1, 4'h0, 2'b00, "muldiv_busy2_flush");
    step(1, 10, 1, 2'b11, 11, 1, 0, 0, 0, 10, 1, 1, 1, 4'h0, 2'b00, "muldiv_busy3");
    step(1, 10, 1, 2'b11, 11, 1, 0, 0, 0, 10, 1, 0, 0, 4'b0001, 2'b01, "muldiv_fwd_ex");
    drain();

    lw_x7();
    step(1, 7, 1, 2'b11, 8, 1, 0, 0, 1, 0, 0, 0, 0, 4'h0, 2'b00, "flush_over_lu");
    step(1, 7, 7, 2'b11, 12, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1010, 2'b00, "flush_ex_bubble");
    drain();

    mul_x10();
    step(1, 10, 1, 2'b11, 11, 1, 0, 0, 0, 10, 1, 1, 1, 4'h0, 2'b00, "busy_pre_reset");
    rst_n = 1'b0;
    push(cyc, 1, 6'd1, "busy_in_reset");
    push(cyc, 2, 6'd1, "busy_in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_all(cyc, 0, 0, 4'h0, 2'b00, "reset_mid_busy");
    step(1, 10, 1, 2'b11, 11, 1, 0, 0, 0, 10, 1, 0, 0, 4'h0, 2'b00, "after_reset_no_replay");
    drain();

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    if (q_cyc.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d want=0", q_cyc.size());
      n_bad += q_cyc.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
